// File: rtl/gpca_op_sequencer_pkg.sv
// rtl/gpca_op_sequencer_pkg.sv - shared constants and types for the gpca operation sequencer
// Purpose: opcode encodings, FSM state encoding, array B/C pattern constants and array field widths.
// Ports: none (package).
package gpca_op_sequencer_pkg;

   localparam int P_W   = 5;    // array P field
   localparam int A_W   = 10;   // array A field
   localparam int BC_W  = 7;    // array B and C fields
   localparam int F_W   = 5;    // array F output
   localparam int S_W   = 11;   // array S output, also result width
   localparam int OPA_W = 10;   // request operand a
   localparam int OPB_W = 3;    // request operand b

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_SQR  = 2'b01;
   localparam logic [1:0] OP_SQRT = 2'b10;
   localparam logic [1:0] OP_DIV  = 2'b11;

   localparam logic [BC_W-1:0] PAT_ONES_LOW = 7'b0011111;
   localparam logic [BC_W-1:0] PAT_SQ_C     = 7'b0100000;

   localparam logic [S_W-1:0] ERR_DATA = 11'h7FF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

endpackage

// File: rtl/gpca_op_sequencer_if.sv
// rtl/gpca_op_sequencer_if.sv - host request/response handshake bundle for the gpca sequencer
// Purpose: groups the request (op/a/b over valid/ready) and response (data/err over valid/ready) signals.
// Signals: req_valid, req_ready, req_op[1:0], req_a[9:0], req_b[2:0],
//          rsp_valid, rsp_ready, rsp_data[10:0], rsp_err.
// Modports: master = host side, slave = sequencer side.
interface gpca_op_sequencer_if;
   import gpca_op_sequencer_pkg::*;

   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [OPA_W-1:0] req_a;
   logic [OPB_W-1:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [S_W-1:0]   rsp_data;
   logic             rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/gpca_op_sequencer_operand_fmt.sv
// rtl/gpca_op_sequencer_operand_fmt.sv - combinational opcode/operand to gpca input formatter
// Purpose: maps op/a/b onto the array mode and field inputs X, P, A, B, C.
// Ports: op[1:0], a[9:0], b[2:0] in; x, p[4:0], a_fmt[9:0], b_fmt[6:0], c_fmt[6:0] out.
module gpca_op_sequencer_operand_fmt
   import gpca_op_sequencer_pkg::*;
(
   input  logic [1:0]       op,
   input  logic [OPA_W-1:0] a,
   input  logic [OPB_W-1:0] b,
   output logic             x,
   output logic [P_W-1:0]   p,
   output logic [A_W-1:0]   a_fmt,
   output logic [BC_W-1:0]  b_fmt,
   output logic [BC_W-1:0]  c_fmt
);

   always_comb begin
      x     = 1'b0;
      p     = '0;
      a_fmt = '0;
      b_fmt = '0;
      c_fmt = '0;
      case (op)
         OP_MUL: begin
            p     = a[4:0];
            b_fmt = {b, 4'b0000};
            c_fmt = {b, 4'b0000};
         end
         OP_SQR: begin
            p     = a[4:0];
            b_fmt = PAT_ONES_LOW;
            c_fmt = PAT_SQ_C;
         end
         OP_SQRT: begin
            x     = 1'b1;
            a_fmt = a;
            b_fmt = PAT_ONES_LOW;
            c_fmt = PAT_SQ_C;
         end
         default: begin
            // divide: dividend sits in the top six bits of A
            x     = 1'b1;
            a_fmt = {a[5:0], 4'b0000};
            b_fmt = {b, 4'b0000};
            c_fmt = {b, 4'b0000};
         end
      endcase
   end

endmodule

// File: rtl/gpca_op_sequencer.sv
// rtl/gpca_op_sequencer.sv - drives a combinational gpca array from a valid/ready request stream
// Purpose: accepts op+operands, holds formatted array inputs for SETTLE_CYCLES, captures F/S,
//          returns the result over valid/ready.
// Ports: clk, rst (sync, active high); host (gpca_op_sequencer_if.slave: req_*/rsp_*);
//        gpca_X, gpca_P[4:0], gpca_A[9:0], gpca_B[6:0], gpca_C[6:0] out; gpca_F[4:0], gpca_S[10:0] in.
// Config: GPCA_SEQ_DIVZERO_CHECK_EN enables the divide-by-zero short-circuit and rsp_err.
module gpca_op_sequencer
   import gpca_op_sequencer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic            clk,
   input  logic            rst,
   gpca_op_sequencer_if.slave host,
   output logic            gpca_X,
   output logic [P_W-1:0]  gpca_P,
   output logic [A_W-1:0]  gpca_A,
   output logic [BC_W-1:0] gpca_B,
   output logic [BC_W-1:0] gpca_C,
   input  logic [F_W-1:0]  gpca_F,
   input  logic [S_W-1:0]  gpca_S
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic             accept;
   logic             div_zero;
   logic [S_W-1:0]   data_q;

   logic             fmt_x;
   logic [P_W-1:0]   fmt_p;
   logic [A_W-1:0]   fmt_a;
   logic [BC_W-1:0]  fmt_b;
   logic [BC_W-1:0]  fmt_c;

   gpca_op_sequencer_operand_fmt u_fmt (
      .op    (host.req_op),
      .a     (host.req_a),
      .b     (host.req_b),
      .x     (fmt_x),
      .p     (fmt_p),
      .a_fmt (fmt_a),
      .b_fmt (fmt_b),
      .c_fmt (fmt_c)
   );

   assign accept         = host.req_valid && (state == ST_IDLE);
   assign cnt_last       = (cnt == CNT_W'(SETTLE_CYCLES - 1));
   assign host.req_ready = (state == ST_IDLE);
   assign host.rsp_valid = (state == ST_RESP);
   assign host.rsp_data  = data_q;

`ifdef GPCA_SEQ_DIVZERO_CHECK_EN
   logic err_q;

   assign div_zero = (host.req_op == OP_DIV) && (host.req_b == '0);

   // error flag only changes on accept, so it stays stable through a stalled response
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= div_zero;
      end
   end

   assign host.rsp_err = err_q;
`else
   assign div_zero     = 1'b0;
   assign host.rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = div_zero ? ST_RESP : ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_last) begin
               state_nxt = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            state_nxt = ST_RESP;
         end
         default: begin
            if (host.rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   // Array inputs are registered on accept and held until the response is consumed,
   // so the combinational array never sees a change while it settles.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         data_q <= '0;
         gpca_X <= 1'b0;
         gpca_P <= '0;
         gpca_A <= '0;
         gpca_B <= '0;
         gpca_C <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cnt <= '0;
                  if (div_zero) begin
                     data_q <= ERR_DATA;
                  end else begin
                     gpca_X <= fmt_x;
                     gpca_P <= fmt_p;
                     gpca_A <= fmt_a;
                     gpca_B <= fmt_b;
                     gpca_C <= fmt_c;
                  end
               end
            end
            ST_SETTLE: begin
               if (!cnt_last) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_CAPTURE: begin
               // root/quotient modes report on F, product modes on S
               data_q <= gpca_X ? {{(S_W-F_W){1'b0}}, gpca_F} : gpca_S;
            end
            default: begin
               if (host.rsp_ready) begin
                  gpca_X <= 1'b0;
                  gpca_P <= '0;
                  gpca_A <= '0;
                  gpca_B <= '0;
                  gpca_C <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpca_op_sequencer.sv
// tb/tb_gpca_op_sequencer.sv - directed self-checking bench for gpca_op_sequencer with an array model
module tb_gpca_op_sequencer;

   localparam int SETTLE = 4;
   localparam int LAT    = SETTLE + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        gpca_X;
   logic [4:0]  gpca_P;
   logic [9:0]  gpca_A;
   logic [6:0]  gpca_B;
   logic [6:0]  gpca_C;
   logic [4:0]  gpca_F;
   logic [10:0] gpca_S;

   int n_checks = 0;
   int n_fail   = 0;

   logic        snap_x;
   logic [4:0]  snap_p;
   logic [9:0]  snap_a;
   logic [6:0]  snap_b;
   logic [6:0]  snap_c;
   int          got_lat;
   logic [10:0] got_data;
   logic        got_err;

   gpca_op_sequencer_if bus();

   gpca_op_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .host   (bus),
      .gpca_X (gpca_X),
      .gpca_P (gpca_P),
      .gpca_A (gpca_A),
      .gpca_B (gpca_B),
      .gpca_C (gpca_C),
      .gpca_F (gpca_F),
      .gpca_S (gpca_S)
   );

   always #5 clk = ~clk;

   // behavioural stand-in for the gpca array
   function automatic logic [10:0] model_s(input logic x, input logic [4:0] p, input logic [6:0] b);
      int r;
      if (x) return 11'd0;
      if (b == 7'b0011111) r = int'(p) * int'(p);
      else r = int'(p) * int'(b[6:4]);
      return r[10:0];
   endfunction

   function automatic logic [4:0] model_f(input logic x, input logic [9:0] a, input logic [6:0] b,
                                          input logic [6:0] c);
      int r;
      if (!x) return 5'd0;
      if (b == 7'b0011111 && c == 7'b0100000) begin
         r = 0;
         while ((r + 1) * (r + 1) <= int'(a)) r++;
      end else if (b[6:4] == 3'd0) begin
         r = 31;
      end else begin
         r = int'(a[9:4]) / int'(b[6:4]);
         if (r > 31) r = 31;
      end
      return r[4:0];
   endfunction

   assign gpca_S = model_s(gpca_X, gpca_P, gpca_B);
   assign gpca_F = model_f(gpca_X, gpca_A, gpca_B, gpca_C);

   task automatic run_op(input logic [1:0] op, input logic [9:0] a, input logic [2:0] b);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.rsp_ready = 1'b0;
      @(posedge clk);
      got_lat = 1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      snap_x = gpca_X; snap_p = gpca_P; snap_a = gpca_A; snap_b = gpca_B; snap_c = gpca_C;
      while (!bus.rsp_valid && got_lat < 50) begin
         @(posedge clk);
         got_lat++;
         @(negedge clk);
      end
      if (!bus.rsp_valid) begin
         n_checks++; n_fail++;
         $display("FAIL rsp_timeout op=%0d: rsp_valid not seen within %0d cycles", op, got_lat);
      end
      got_data = bus.rsp_data;
      got_err  = bus.rsp_err;
   endtask

   task automatic release_rsp();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
      n_checks++; if (bus.rsp_data !== 11'd0) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
      n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
      n_checks++; if ({gpca_X, gpca_P, gpca_A, gpca_B, gpca_C} !== 30'd0) begin n_fail++; $display("FAIL reset_gpca got=%h exp=0", {gpca_X, gpca_P, gpca_A, gpca_B, gpca_C}); end
   endtask

   task automatic test_mul();
      run_op(2'b00, 10'd5, 3'd7);
      n_checks++; if (snap_x !== 1'b0) begin n_fail++; $display("FAIL mul_x got=%b exp=0", snap_x); end
      n_checks++; if (snap_p !== 5'b00101) begin n_fail++; $display("FAIL mul_p got=%b exp=00101", snap_p); end
      n_checks++; if (snap_a !== 10'd0) begin n_fail++; $display("FAIL mul_a got=%b exp=0", snap_a); end
      n_checks++; if (snap_b !== 7'b1110000 || snap_c !== 7'b1110000) begin n_fail++; $display("FAIL mul_bc got=%b/%b exp=1110000", snap_b, snap_c); end
      n_checks++; if (got_data !== 11'd35) begin n_fail++; $display("FAIL mul_data got=%0d exp=35", got_data); end
      n_checks++; if (got_lat !== LAT) begin n_fail++; $display("FAIL mul_latency got=%0d exp=%0d", got_lat, LAT); end
      n_checks++; if (got_err !== 1'b0) begin n_fail++; $display("FAIL mul_err got=%b exp=0", got_err); end
      n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL mul_busy_ready got=%b exp=0", bus.req_ready); end
      release_rsp();
      n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mul_idle ready/valid got=%b/%b exp=1/0", bus.req_ready, bus.rsp_valid); end
      n_checks++; if ({gpca_X, gpca_P, gpca_A, gpca_B, gpca_C} !== 30'd0) begin n_fail++; $display("FAIL mul_gpca_cleared got=%h exp=0", {gpca_X, gpca_P, gpca_A, gpca_B, gpca_C}); end
      // upper operand bits are ignored for MUL
      run_op(2'b00, 10'h3FF, 3'd7);
      n_checks++; if (snap_p !== 5'd31) begin n_fail++; $display("FAIL mul_max_p got=%0d exp=31", snap_p); end
      n_checks++; if (got_data !== 11'd217) begin n_fail++; $display("FAIL mul_max_data got=%0d exp=217", got_data); end
      release_rsp();
   endtask

   task automatic test_sqr();
      run_op(2'b01, 10'd5, 3'd6);
      n_checks++; if (snap_x !== 1'b0 || snap_p !== 5'd5) begin n_fail++; $display("FAIL sqr_xp got=%b/%0d exp=0/5", snap_x, snap_p); end
      n_checks++; if (snap_b !== 7'b0011111 || snap_c !== 7'b0100000) begin n_fail++; $display("FAIL sqr_bc got=%b/%b exp=0011111/0100000", snap_b, snap_c); end
      n_checks++; if (got_data !== 11'd25) begin n_fail++; $display("FAIL sqr_data got=%0d exp=25", got_data); end
      release_rsp();
   endtask

   task automatic test_sqrt();
      run_op(2'b10, 10'd25, 3'd0);
      n_checks++; if (snap_x !== 1'b1 || snap_p !== 5'd0) begin n_fail++; $display("FAIL sqrt_xp got=%b/%0d exp=1/0", snap_x, snap_p); end
      n_checks++; if (snap_a !== 10'b0000011001) begin n_fail++; $display("FAIL sqrt_a got=%b exp=0000011001", snap_a); end
      n_checks++; if (got_data !== 11'd5) begin n_fail++; $display("FAIL sqrt_data got=%0d exp=5", got_data); end
      n_checks++; if (got_lat !== LAT) begin n_fail++; $display("FAIL sqrt_latency got=%0d exp=%0d", got_lat, LAT); end
      release_rsp();
      run_op(2'b10, 10'd1023, 3'd0);
      n_checks++; if (got_data !== 11'd31) begin n_fail++; $display("FAIL sqrt_max_data got=%0d exp=31", got_data); end
      release_rsp();
   endtask

   task automatic test_div();
      run_op(2'b11, 10'd35, 3'd5);
      n_checks++; if (snap_x !== 1'b1) begin n_fail++; $display("FAIL div_x got=%b exp=1", snap_x); end
      n_checks++; if (snap_a !== 10'b1000110000) begin n_fail++; $display("FAIL div_a got=%b exp=1000110000", snap_a); end
      n_checks++; if (snap_b !== 7'b1010000 || snap_c !== 7'b1010000) begin n_fail++; $display("FAIL div_bc got=%b/%b exp=1010000", snap_b, snap_c); end
      n_checks++; if (got_data !== 11'd7) begin n_fail++; $display("FAIL div_data got=%0d exp=7", got_data); end
      release_rsp();
   endtask

   task automatic test_back_to_back();
      run_op(2'b00, 10'd3, 3'd3);
      // second request waits while the first response is stalled
      bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_a = 10'd7; bus.req_b = 3'd0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 11'd9) begin n_fail++; $display("FAIL bp_hold cyc=%0d valid=%b data=%0d exp=1/9", i, bus.rsp_valid, bus.rsp_data); end
         n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, bus.req_ready); end
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle ready/valid got=%b/%b exp=1/0", bus.req_ready, bus.rsp_valid); end
      @(posedge clk);
      got_lat = 1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      while (!bus.rsp_valid && got_lat < 50) begin
         @(posedge clk);
         got_lat++;
         @(negedge clk);
      end
      n_checks++; if (bus.rsp_data !== 11'd49 || got_lat !== LAT) begin n_fail++; $display("FAIL b2b_second data=%0d lat=%0d exp=49/%0d", bus.rsp_data, got_lat, LAT); end
      release_rsp();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = 2'b11; bus.req_a = 10'd35; bus.req_b = 3'd5;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid ready/valid got=%b/%b exp=1/0", bus.req_ready, bus.rsp_valid); end
      n_checks++; if ({gpca_X, gpca_P, gpca_A, gpca_B, gpca_C} !== 30'd0) begin n_fail++; $display("FAIL rstmid_gpca got=%h exp=0", {gpca_X, gpca_P, gpca_A, gpca_B, gpca_C}); end
      n_checks++; if (bus.rsp_data !== 11'd0) begin n_fail++; $display("FAIL rstmid_data got=%0d exp=0", bus.rsp_data); end
      repeat (LAT + 2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_lost got=%b exp=0", bus.rsp_valid); end
      run_op(2'b01, 10'd6, 3'd0);
      n_checks++; if (got_data !== 11'd36) begin n_fail++; $display("FAIL rstmid_recover got=%0d exp=36", got_data); end
      release_rsp();
   endtask

   task automatic test_div_zero();
      run_op(2'b11, 10'd10, 3'd0);
`ifdef GPCA_SEQ_DIVZERO_CHECK_EN
      n_checks++; if (got_lat !== 1) begin n_fail++; $display("FAIL divz_latency got=%0d exp=1", got_lat); end
      n_checks++; if (got_data !== 11'h7FF || got_err !== 1'b1) begin n_fail++; $display("FAIL divz_result data=%h err=%b exp=7ff/1", got_data, got_err); end
      n_checks++; if ({snap_x, snap_p, snap_a, snap_b, snap_c} !== 30'd0) begin n_fail++; $display("FAIL divz_gpca got=%h exp=0", {snap_x, snap_p, snap_a, snap_b, snap_c}); end
`else
      n_checks++; if (got_lat !== LAT) begin n_fail++; $display("FAIL divz_latency got=%0d exp=%0d", got_lat, LAT); end
      n_checks++; if (got_data !== 11'd31 || got_err !== 1'b0) begin n_fail++; $display("FAIL divz_result data=%0d err=%b exp=31/0", got_data, got_err); end
      n_checks++; if (snap_a !== 10'b0010100000 || snap_x !== 1'b1) begin n_fail++; $display("FAIL divz_gpca a=%b x=%b exp=0010100000/1", snap_a, snap_x); end
`endif
      release_rsp();
      run_op(2'b00, 10'd2, 3'd3);
      n_checks++; if (got_data !== 11'd6 || got_err !== 1'b0) begin n_fail++; $display("FAIL divz_after data=%0d err=%b exp=6/0", got_data, got_err); end
      release_rsp();
   endtask

   initial begin
      test_reset();
      test_mul();
      test_sqr();
      test_sqrt();
      test_div();
      test_back_to_back();
      test_reset_mid();
      test_div_zero();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
